// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial add/subtract unit.
// The requester holds the master side; the adder holds the slave side.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow, zero
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, with a single
// carry flip-flop linking the bits and a start/done handshake.
module xor_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_shiftA;
  logic [WIDTH-1:0] r_shiftB;
  logic [WIDTH-2:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_load;
  logic             w_last;
  logic             w_halfSum;
  logic             w_sumBit;
  logic             w_newCarry;
  logic [WIDTH-1:0] w_finalAcc;

  assign w_load = (r_state != RUN) && bus.start;
  assign w_last = (r_state == RUN) && (r_cnt == LAST_CNT);

  xor_gate u_xorAb (
    .i_a (r_shiftA[0]),
    .i_b (r_shiftB[0]),
    .o_y (w_halfSum)
  );

  xor_gate u_xorCarry (
    .i_a (w_halfSum),
    .i_b (r_carry),
    .o_y (w_sumBit)
  );

  // Majority of a, b, carry, reusing the first xor stage.
  assign w_newCarry = (r_shiftA[0] & r_shiftB[0]) | (r_carry & w_halfSum);
  assign w_finalAcc = {w_sumBit, r_acc};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_cnt == LAST_CNT) w_nextState = DONE;
      DONE:    w_nextState = bus.start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // busy/done come straight from flops so the handshake never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState == RUN);
      r_done  <= (w_nextState == DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shiftA   <= '0;
      r_shiftB   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_load) begin
      r_shiftA <= bus.a;
      r_shiftB <= bus.sub ? ~bus.b : bus.b;
      r_carry  <= bus.sub;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_shiftA <= {1'b0, r_shiftA[WIDTH-1:1]};
      r_shiftB <= {1'b0, r_shiftB[WIDTH-1:1]};
      r_acc    <= w_finalAcc[WIDTH-1:1];
      r_carry  <= w_newCarry;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum      <= w_finalAcc;
        r_cout     <= w_newCarry;
        r_overflow <= r_carry ^ w_newCarry;
        r_zero     <= (w_finalAcc == '0);
      end
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_overflow;
  assign bus.zero     = r_zero;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, handshake and reset
// behaviour, then randomized operations against an arithmetic reference model.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] expSum,
                             input logic expCout, input logic expOv, input logic expZero);
    checkVal({tag, " sum"}, 32'(bus.sum), 32'(expSum));
    checkVal({tag, " cout"}, 32'(bus.cout), 32'(expCout));
    checkVal({tag, " overflow"}, 32'(bus.overflow), 32'(expOv));
    checkVal({tag, " zero"}, 32'(bus.zero), 32'(expZero));
  endtask

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                       output logic [WIDTH-1:0] expSum, output logic expCout,
                       output logic expOv, output logic expZero);
    int ua, ub, ur, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ur      = ua + ub;
      sr      = sa + sb;
      expCout = (ur >= (1 << WIDTH));
    end else begin
      ur      = ua - ub;
      sr      = sa - sb;
      expCout = (ua >= ub);
    end
    expSum  = WIDTH'(ur);
    expOv   = (sr > ((1 << (WIDTH - 1)) - 1)) || (sr < -(1 << (WIDTH - 1)));
    expZero = (expSum == '0);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input logic [WIDTH-1:0] expSum, input logic expCout,
                       input logic expOv, input logic expZero);
    int cyc;
    applyStimulus(a, b, s);
    checkVal({tag, " busy"}, 32'(bus.busy), 32'd1);
    waitDone(cyc);
    checkVal({tag, " latency"}, 32'(cyc), 32'(WIDTH));
    checkOutput(tag, expSum, expCout, expOv, expZero);
    @(negedge clk);
    checkVal({tag, " done pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb, eSum;
    logic             rs, eCout, eOv, eZero;
    logic [WIDTH-1:0] qa [4];
    logic [WIDTH-1:0] qb [4];
    logic             qs [4];
    int               cyc, doneSeen, busySeen;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    checkVal("reset busy", 32'(bus.busy), 32'd0);
    checkVal("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    runOp("add 35+4A", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
    runOp("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    runOp("sub 03-05", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);

    // A second start during RUN must be dropped, not queued.
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    bus.a     = 8'hAA;
    bus.b     = 8'hCC;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(cyc);
    checkVal("ignored start latency", 32'(cyc), 32'd4);
    checkOutput("ignored start", 8'h46, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("ignored start no requeue busy", 32'(bus.busy), 32'd0);
    checkVal("ignored start no requeue done", 32'(bus.done), 32'd0);

    runOp("wrap FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    applyStimulus(8'h55, 8'h22, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkVal("midrun reset busy", 32'(bus.busy), 32'd0);
    checkVal("midrun reset done", 32'(bus.done), 32'd0);
    checkOutput("midrun reset", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    doneSeen = 0;
    busySeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
      if (bus.busy === 1'b1) busySeen++;
    end
    checkVal("post reset no done", 32'(doneSeen), 32'd0);
    checkVal("post reset no busy", 32'(busySeen), 32'd0);

    // Start held high: a new operand set is taken every WIDTH+1 clocks.
    for (int k = 0; k < 4; k++) begin
      qa[k] = WIDTH'($urandom);
      qb[k] = WIDTH'($urandom);
      qs[k] = 1'($urandom);
    end
    @(negedge clk);
    bus.a     = qa[0];
    bus.b     = qb[0];
    bus.sub   = qs[0];
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        bus.a   = qa[k+1];
        bus.b   = qb[k+1];
        bus.sub = qs[k+1];
      end else begin
        bus.start = 1'b0;
      end
      waitDone(cyc);
      checkVal($sformatf("b2b%0d latency", k), 32'(cyc), 32'(WIDTH));
      model(qa[k], qb[k], qs[k], eSum, eCout, eOv, eZero);
      checkOutput($sformatf("b2b%0d", k), eSum, eCout, eOv, eZero);
      @(negedge clk);
      if (k < 3) checkVal($sformatf("b2b%0d restart busy", k), 32'(bus.busy), 32'd1);
      else       checkVal("b2b end done pulse", 32'(bus.done), 32'd0);
    end

    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = 1'($urandom);
      model(ra, rb, rs, eSum, eCout, eOv, eZero);
      runOp($sformatf("rand%0d %h%s%h", n, ra, rs ? "-" : "+", rb), ra, rb, rs,
            eSum, eCout, eOv, eZero);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
